// File: rtl/imm_gen_stage.sv
// Immediate-operand producer for the 16-bit decode stage: classifies R/I6/I3 instructions,
// registers the controls and immediate, and folds an EXT prefix into the next I6 immediate.
module imm_gen_stage #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned EXT_BITS = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] instr_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] instr_out,
    output logic             imm_Control_6,
    output logic             imm_Control_3,
    output logic [WIDTH-1:0] rs2ValueImm,
    output logic             prefix_drop
);

    typedef enum logic {
        NO_PREFIX,
        PREFIX_HELD
    } state_t;

    state_t              state, state_next;
    logic [EXT_BITS-1:0] prefix;
    logic                drop_next;

    logic [3:0]       opcode;
    logic             accept;
    logic             is_ext, is_i6, is_i3;
    logic             dec_c6, dec_c3;
    logic [WIDTH-1:0] dec_imm;

    assign opcode   = instr_in[WIDTH-1:WIDTH-4];
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign is_ext   = (opcode == 4'hF);
    assign is_i6    = (opcode[3:2] == 2'b10);
    assign is_i3    = (opcode[3:2] == 2'b11) && !is_ext;

    always_comb begin
        dec_c6  = 1'b0;
        dec_c3  = 1'b0;
        dec_imm = '0;
        if (is_i6) begin
            dec_c6 = 1'b1;
            if (state == PREFIX_HELD)
                dec_imm = {prefix, instr_in[5:0]};
            else
                dec_imm = {{(WIDTH-6){instr_in[5]}}, instr_in[5:0]};
        end else if (is_i3) begin
            dec_c3  = 1'b1;
            dec_imm = {{(WIDTH-3){1'b0}}, instr_in[2:0]};
        end
    end

    // Any accepted non-I6 word while a prefix is held throws that prefix away.
    always_comb begin
        state_next = state;
        drop_next  = 1'b0;
        if (accept) begin
            case (state)
                NO_PREFIX: begin
                    if (is_ext)
                        state_next = PREFIX_HELD;
                end
                PREFIX_HELD: begin
                    if (is_ext) begin
                        drop_next = 1'b1;
                    end else begin
                        state_next = NO_PREFIX;
                        drop_next  = !is_i6;
                    end
                end
                default: state_next = NO_PREFIX;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= NO_PREFIX;
            prefix        <= '0;
            prefix_drop   <= 1'b0;
            out_valid     <= 1'b0;
            instr_out     <= '0;
            imm_Control_6 <= 1'b0;
            imm_Control_3 <= 1'b0;
            rs2ValueImm   <= '0;
        end else if (flush) begin
            state       <= NO_PREFIX;
            prefix_drop <= 1'b0;
            out_valid   <= 1'b0;
        end else begin
            state       <= state_next;
            prefix_drop <= drop_next;
            if (accept && is_ext) begin
                prefix <= instr_in[EXT_BITS-1:0];
                if (out_valid && out_ready)
                    out_valid <= 1'b0;
            end else if (accept) begin
                out_valid     <= 1'b1;
                instr_out     <= instr_in;
                imm_Control_6 <= dec_c6;
                imm_Control_3 <= dec_c3;
                rs2ValueImm   <= dec_imm;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_imm_gen_stage.sv
// Scoreboard bench for imm_gen_stage: directed scenarios then random traffic, checked
// against an instruction-level model of the immediate rules.
module tb_imm_gen_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] instr_in = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] instr_out;
    logic        imm_Control_6;
    logic        imm_Control_3;
    logic [15:0] rs2ValueImm;
    logic        prefix_drop;

    imm_gen_stage #(.WIDTH(16), .EXT_BITS(10)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .instr_in(instr_in),
        .out_valid(out_valid), .out_ready(out_ready), .instr_out(instr_out),
        .imm_Control_6(imm_Control_6), .imm_Control_3(imm_Control_3),
        .rs2ValueImm(rs2ValueImm), .prefix_drop(prefix_drop)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] instr;
        logic        c6;
        logic        c3;
        logic [15:0] imm;
    } item_t;

    item_t sb[$];
    int    checks = 0;
    int    errors = 0;
    bit    started = 0;

    // model state
    bit    held = 0;
    int    pfx = 0;
    bit    model_ov = 0;
    bit    push_pend = 0;
    item_t pend_item;
    bit    drop_pend = 0;
    bit    exp_drop = 0;
    bit    rst_pend = 1;
    bit    rst_seen = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: outputs are stable at negedge; inputs seen here are those of the coming edge.
    initial begin
        forever begin
            @(negedge clk);
            if (started) begin
                chk("in_ready", 16'(in_ready), 16'((sb.size() == 0) || out_ready));
                chk("out_valid", 16'(out_valid), 16'(sb.size() != 0));
                chk("prefix_drop", 16'(prefix_drop), 16'(exp_drop));
                if (rst_seen) begin
                    chk("rst_instr_out", instr_out, 16'h0000);
                    chk("rst_ctrl", {14'b0, imm_Control_6, imm_Control_3}, 16'h0000);
                    chk("rst_imm", rs2ValueImm, 16'h0000);
                end
                if (sb.size() != 0) begin
                    chk("instr_out", instr_out, sb[0].instr);
                    chk("imm_Control_6", 16'(imm_Control_6), 16'(sb[0].c6));
                    chk("imm_Control_3", 16'(imm_Control_3), 16'(sb[0].c3));
                    chk("rs2ValueImm", rs2ValueImm, sb[0].imm);
                end
                if (rst || flush)
                    sb.delete();
                else if (sb.size() != 0 && out_ready)
                    void'(sb.pop_front());
            end
        end
    end

    // One clock of stimulus; the model decides what the coming edge must do.
    task automatic cyc(input bit r, input bit f, input bit v, input logic [15:0] ins, input bit ordy);
        int  op;
        bit  acc;
        @(posedge clk);
        #1;
        if (push_pend) sb.push_back(pend_item);
        push_pend = 0;
        exp_drop  = drop_pend;
        rst_seen  = rst_pend;
        rst = r; flush = f; in_valid = v; instr_in = ins; out_ready = ordy;
        #1;
        drop_pend = 0;
        rst_pend  = r;
        op = int'(ins) / 4096;
        if (r) begin
            held = 0; pfx = 0; model_ov = 0;
        end else if (f) begin
            held = 0; model_ov = 0;
        end else begin
            acc = v && (!model_ov || ordy);
            if (acc && op == 15) begin
                drop_pend = held;
                held = 1;
                pfx = int'(ins) % 1024;
                if (model_ov && ordy) model_ov = 0;
            end else if (acc) begin
                pend_item.instr = ins;
                pend_item.c6 = (op >= 8 && op <= 11);
                pend_item.c3 = (op >= 12 && op <= 14);
                if (pend_item.c6) begin
                    if (held)
                        pend_item.imm = 16'(pfx * 64 + int'(ins) % 64);
                    else if ((int'(ins) % 64) >= 32)
                        pend_item.imm = 16'(65536 - 64 + int'(ins) % 64);
                    else
                        pend_item.imm = 16'(int'(ins) % 64);
                end else if (pend_item.c3) begin
                    pend_item.imm = 16'(int'(ins) % 8);
                end else begin
                    pend_item.imm = 16'h0000;
                end
                drop_pend = held && !pend_item.c6;
                held = 0;
                push_pend = 1;
                model_ov = 1;
            end else if (model_ov && ordy) begin
                model_ov = 0;
            end
        end
    endtask

    initial begin
        logic [15:0] w;
        cyc(1, 0, 0, 16'h0000, 1);
        started = 1;
        cyc(1, 0, 0, 16'h0000, 1);
        // 1: sign-extended I6
        cyc(0, 0, 1, 16'h803F, 1);
        cyc(0, 0, 0, 16'h0000, 1);
        // 2: I3 then R back-to-back
        cyc(0, 0, 1, 16'hC005, 1);
        cyc(0, 0, 1, 16'h1234, 1);
        cyc(0, 0, 0, 16'h0000, 1);
        // 3: EXT folded into I6
        cyc(0, 0, 1, 16'hF2AB, 1);
        cyc(0, 0, 1, 16'h8015, 1);
        cyc(0, 0, 0, 16'h0000, 1);
        // 4: prefix dropped by I3, then replaced by EXT
        cyc(0, 0, 1, 16'hF001, 1);
        cyc(0, 0, 1, 16'hC003, 1);
        cyc(0, 0, 1, 16'hF3FF, 1);
        cyc(0, 0, 1, 16'hF000, 1);
        cyc(0, 0, 1, 16'hA020, 1);
        cyc(0, 0, 0, 16'h0000, 1);
        // 5: backpressure holds the output register
        cyc(0, 0, 1, 16'h8002, 1);
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 16'h0001, 0);
        cyc(0, 0, 1, 16'h0001, 1);
        cyc(0, 0, 0, 16'h0000, 1);
        // 6: flush and reset discard a held prefix
        cyc(0, 0, 1, 16'h8003, 1);
        cyc(0, 0, 1, 16'hF155, 1);
        cyc(0, 1, 1, 16'hC007, 1);
        cyc(0, 0, 1, 16'h8001, 1);
        cyc(0, 0, 1, 16'hF155, 1);
        cyc(1, 0, 0, 16'h0000, 1);
        cyc(0, 0, 1, 16'h8001, 1);
        cyc(0, 0, 0, 16'h0000, 1);
        // random traffic, EXT words favoured
        for (int i = 0; i < 3000; i++) begin
            w = 16'($urandom);
            if ($urandom_range(0, 4) == 0) w[15:12] = 4'hF;
            cyc($urandom_range(0, 99) == 0, $urandom_range(0, 15) == 0,
                $urandom_range(0, 3) != 0, w, $urandom_range(0, 3) != 0);
        end
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 16'h0000, 1);
        chk("drained", 16'(sb.size()), 16'h0000);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
